// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register bank with writer scoreboard.
// Optional feature macro: REGBANK_BYPASS_EN (write-through read forwarding).
package regbank_pkg;

    localparam int REGBANK_DATA_W  = 32;
    localparam int REGBANK_ADDR_W  = 4;
    // Widest register index the PC-index helper understands.
    localparam int REGBANK_IDX_MAX = 8;

    // Outstanding-writer count per register.
    typedef logic [1:0] sb_count_t;

    // True when the low 'width' bits of addr are all ones (the PC alias).
    function automatic logic is_pc_idx(input logic [REGBANK_IDX_MAX-1:0] addr,
                                       input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int b = 0; b < REGBANK_IDX_MAX; b++) begin
            if ((b < width) && !addr[b]) begin
                all_ones = 1'b0;
            end
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register outstanding-writer counters: reserve/retire update,
// reservation acceptance and per-read-port pending lookup.
// Optional feature macro: REGBANK_BYPASS_EN (pending hides a retiring sole writer).
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = REGBANK_ADDR_W,
    parameter int READ_PORTS = 2,
    parameter int SB_MAX     = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS-1:0]                 rd_pending,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic                                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0]                 rsv_addr,
    output logic                                  rsv_ready
);

    localparam int        DEPTH    = 1 << ADDR_WIDTH;
    localparam sb_count_t SB_LIMIT = sb_count_t'(SB_MAX);

    sb_count_t r_count [DEPTH];

    sb_count_t w_rsv_cnt;
    sb_count_t w_rsv_eff;
    logic      w_rsv_retire_same;
    logic      w_rsv_fire;

    // Acceptance looks at the count as it will be after a same-cycle retire,
    // so a full register that is draining can still take a new writer.
    always_comb begin
        w_rsv_cnt         = r_count[rsv_addr];
        w_rsv_retire_same = wr_en && (wr_addr == rsv_addr) && (w_rsv_cnt != 2'd0);
        w_rsv_eff         = w_rsv_retire_same ? (w_rsv_cnt - 2'd1) : w_rsv_cnt;
        rsv_ready         = (w_rsv_eff < SB_LIMIT);
        w_rsv_fire        = rsv_valid && rsv_ready;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cnt
            logic w_inc;
            logic w_dec;
            assign w_inc = w_rsv_fire && (rsv_addr == ADDR_WIDTH'(gi));
            assign w_dec = wr_en && (wr_addr == ADDR_WIDTH'(gi));

            // Reserve and retire on the same index cancel; retire saturates at zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count[gi] <= 2'd0;
                end else if (w_inc && !w_dec) begin
                    r_count[gi] <= r_count[gi] + 2'd1;
                end else if (w_dec && !w_inc && (r_count[gi] != 2'd0)) begin
                    r_count[gi] <= r_count[gi] - 2'd1;
                end
            end
        end

        for (gi = 0; gi < READ_PORTS; gi++) begin : g_pend
            sb_count_t w_cnt;
            assign w_cnt = r_count[rd_addr[gi]];
`ifdef REGBANK_BYPASS_EN
            // A sole writer retiring this cycle is forwarded, so it no longer blocks.
            assign rd_pending[gi] = (w_cnt != 2'd0) &&
                                    !((w_cnt == 2'd1) && wr_en && (wr_addr == rd_addr[gi]));
`else
            assign rd_pending[gi] = (w_cnt != 2'd0);
`endif
        end
    endgenerate

endmodule

// File: rtl/register_bank_sb.sv
// General-purpose register bank: combinational read ports, one synchronous
// write port, PC alias on the all-ones index, registered PC-load report and
// a writer scoreboard for the hazard unit.
// Optional feature macro: REGBANK_BYPASS_EN (same-cycle write-through forwarding).
module register_bank_sb
    import regbank_pkg::*;
#(
    parameter int DATA_WIDTH = REGBANK_DATA_W,
    parameter int ADDR_WIDTH = REGBANK_ADDR_W,
    parameter int READ_PORTS = 2,
    parameter int SB_MAX     = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]                 rd_pending,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic [DATA_WIDTH-1:0]                 pc,
    input  logic                                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0]                 rsv_addr,
    output logic                                  rsv_ready,
    output logic                                  pc_load,
    output logic [DATA_WIDTH-1:0]                 pc_load_value
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The PC slot exists but is never written; reads of it are redirected to pc.
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic                  r_pc_load;
    logic [DATA_WIDTH-1:0] r_pc_load_value;
    logic                  w_wr_is_pc;

    assign w_wr_is_pc = is_pc_idx(REGBANK_IDX_MAX'(wr_addr), ADDR_WIDTH);

    // Data array write; writes to the PC index are diverted to the PC-load report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else if (wr_en && !w_wr_is_pc) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // One-cycle PC-load pulse; the value is held until the next PC write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_load       <= 1'b0;
            r_pc_load_value <= '0;
        end else begin
            r_pc_load <= wr_en && w_wr_is_pc;
            if (wr_en && w_wr_is_pc) begin
                r_pc_load_value <= wr_data;
            end
        end
    end

    assign pc_load       = r_pc_load;
    assign pc_load_value = r_pc_load_value;

    genvar gi;
    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
            logic w_port_pc;
            logic w_fwd;
            assign w_port_pc = is_pc_idx(REGBANK_IDX_MAX'(rd_addr[gi]), ADDR_WIDTH);
`ifdef REGBANK_BYPASS_EN
            assign w_fwd = wr_en && (wr_addr == rd_addr[gi]) && !w_port_pc;
`else
            assign w_fwd = 1'b0;
`endif
            assign rd_data[gi] = w_port_pc ? pc :
                                 (w_fwd ? wr_data : r_regs[rd_addr[gi]]);
        end
    endgenerate

    regbank_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_PORTS (READ_PORTS),
        .SB_MAX     (SB_MAX)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_pending (rd_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready)
    );

endmodule
